// File: rtl/downstream_ahbif.sv
// AHB-Lite single-word write master: drains 64-bit qwords from the downstream aligner into a destination buffer.
// Define DOWNSTREAM_INCR_BURST_EN to mark runs of words as INCR bursts (SEQ within a qword).
module downstream_ahbif (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    output logic        done,
    input  logic [31:0] dst_addr,
    input  logic [15:0] dst_length,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [63:0] data,
    input  logic        data_valid,
    output logic        data_ready
);
    // state   | meaning
    // S_IDLE  | waiting for start, or holding done until start drops
    // S_LOAD  | fetching the next qword from the aligner
    // S_ADDR  | address phase pending on the bus
    // S_LAST  | final data phase outstanding
    // S_PAUSE | suspended; outstanding data phase drains on hready
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDR, S_LAST, S_PAUSE} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t      state, state_nx;
    logic [31:0] haddr_nx, hwdata_nx;
    logic [1:0]  htrans_nx;
    logic        done_nx;
    logic [14:0] remaining, remaining_nx;
    logic        wsel, wsel_nx;
    logic [63:0] qbuf, qbuf_nx;
    logic [16:0] len_sum;
    logic [14:0] words;
    logic [31:0] haddr_inc;
    logic [1:0]  cont_trans;
    logic        unused_bits;

    assign len_sum   = {1'b0, dst_length} + 17'd3;
    assign words     = len_sum[16:2];
    assign haddr_inc = haddr + 32'd4;
    assign unused_bits = ^{dst_addr[1:0], len_sum[1:0]};

`ifdef DOWNSTREAM_INCR_BURST_EN
    // A 1KB crossing must restart the burst.
    assign cont_trans = (haddr_inc[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
    assign hburst     = (htrans != HT_IDLE) ? 3'b001 : 3'b000;
`else
    assign cont_trans = HT_NONSEQ;
    assign hburst     = 3'b000;
`endif

    assign hwrite     = (htrans != HT_IDLE);
    assign hsize      = 3'b010;
    assign data_ready = (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            haddr     <= 32'd0;
            htrans    <= HT_IDLE;
            hwdata    <= 32'd0;
            done      <= 1'b0;
            remaining <= 15'd0;
            wsel      <= 1'b0;
            qbuf      <= 64'd0;
        end else begin
            state     <= state_nx;
            haddr     <= haddr_nx;
            htrans    <= htrans_nx;
            hwdata    <= hwdata_nx;
            done      <= done_nx;
            remaining <= remaining_nx;
            wsel      <= wsel_nx;
            qbuf      <= qbuf_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        haddr_nx     = haddr;
        htrans_nx    = htrans;
        hwdata_nx    = hwdata;
        done_nx      = done;
        remaining_nx = remaining;
        wsel_nx      = wsel;
        qbuf_nx      = qbuf;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    if (words == 15'd0) begin
                        done_nx = 1'b1;
                    end else begin
                        haddr_nx     = {dst_addr[31:2], 2'b00};
                        wsel_nx      = dst_addr[2];
                        remaining_nx = words;
                        state_nx     = S_LOAD;
                    end
                end else if (done && !start) begin
                    done_nx = 1'b0;
                end
            end
            S_LOAD: begin
                htrans_nx = HT_IDLE;
                if (data_valid) begin
                    qbuf_nx   = data;
                    htrans_nx = HT_NONSEQ;
                    state_nx  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hready) begin
                    hwdata_nx    = wsel ? qbuf[63:32] : qbuf[31:0];
                    haddr_nx     = haddr_inc;
                    remaining_nx = remaining - 15'd1;
                    wsel_nx      = ~wsel;
                    if (remaining == 15'd1) begin
                        htrans_nx = HT_IDLE;
                        state_nx  = S_LAST;
                    end else if (pause) begin
                        htrans_nx = HT_IDLE;
                        state_nx  = S_PAUSE;
                    end else if (wsel) begin
                        htrans_nx = HT_IDLE;
                        state_nx  = S_LOAD;
                    end else begin
                        htrans_nx = cont_trans;
                    end
                end
            end
            S_LAST: begin
                htrans_nx = HT_IDLE;
                if (hready) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_PAUSE: begin
                htrans_nx = HT_IDLE;
                if (!pause) begin
                    if (!wsel) begin
                        state_nx = S_LOAD;
                    end else begin
                        htrans_nx = HT_NONSEQ;
                        state_nx  = S_ADDR;
                    end
                end
            end
            default: begin
                htrans_nx = HT_IDLE;
                state_nx  = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_downstream_ahbif.sv
// Self-checking bench for downstream_ahbif: vector table of transfers, bus-monitor scoreboard, hand-written corner cases.
module tb_downstream_ahbif;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        done;
    logic [31:0] dst_addr = 32'd0;
    logic [15:0] dst_length = 16'd0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic [63:0] data;
    logic        data_valid = 1'b1;
    logic        data_ready;

    downstream_ahbif dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .done(done),
        .dst_addr(dst_addr), .dst_length(dst_length),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready),
        .data(data), .data_valid(data_valid), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        bit          vr;
        bit          hr;
        int          words;
        int          qwords;
    } vec_t;

    wr_t         exp_q[$];
    logic [1:0]  acc_htrans[$];
    logic [31:0] acc_haddr[$];
    logic [2:0]  acc_hburst[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt, acc_cnt, hs_cnt, trans_cnt, rdy_cnt, done_cyc, last_wr_cyc, start_cyc;
    bit done_seen = 0, dp_valid = 0, hs_flag = 0, v_rand = 0, h_rand = 0;
    logic [31:0] dp_addr;
    logic [31:0] tag = 32'd0;
    int qidx = 0;

    // Aligner model: qword k of the current transfer carries words tag+2k and tag+2k+1.
    assign data = {tag + 32'(2 * qidx) + 32'd1, tag + 32'(2 * qidx)};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor / scoreboard consumer, sampled mid-low-phase after stimulus settles.
    always begin : monitor
        wr_t e;
        @(negedge clk);
        #2;
        cyc++;
        if (rst) begin
            dp_valid = 0;
            hs_flag  = 0;
        end else begin
            if (data_ready) rdy_cnt++;
            if (htrans != 2'b00) trans_cnt++;
            if (dp_valid && hready) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                dp_valid = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", dp_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", dp_addr, e.addr);
                    chk("wr_data", hwdata, e.data);
                end
            end
            if (htrans != 2'b00 && hready) begin
                dp_valid = 1;
                dp_addr  = haddr;
                acc_cnt++;
                acc_htrans.push_back(htrans);
                acc_haddr.push_back(haddr);
                acc_hburst.push_back(hburst);
                chk("hwrite", {31'd0, hwrite}, 32'd1);
                chk("hsize", {29'd0, hsize}, 32'd2);
            end
            hs_flag = data_ready && data_valid;
            if (done && !done_seen) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    // Aligner / slave stimulus, applied just after each rising edge.
    always begin : driver
        @(posedge clk);
        #1;
        if (hs_flag) begin
            qidx++;
            hs_cnt++;
            hs_flag = 0;
        end
        if (v_rand) data_valid = 1'($urandom_range(0, 1));
        if (h_rand) hready = 1'($urandom_range(0, 1));
    end

    task automatic begin_xfer(input logic [31:0] addr, input logic [15:0] len, input bit vr,
                              input bit hr, input int words, input logic [31:0] tg);
        logic [31:0] base;
        base = {addr[31:2], 2'b00};
        tag = tg;
        qidx = 0;
        wr_cnt = 0; acc_cnt = 0; hs_cnt = 0; trans_cnt = 0; rdy_cnt = 0;
        done_seen = 0; last_wr_cyc = -1; done_cyc = -1;
        acc_htrans.delete(); acc_haddr.delete(); acc_hburst.delete();
        for (int j = 0; j < words; j++)
            exp_q.push_back('{base + 32'(4 * j), tg + {31'd0, addr[2]} + 32'(j)});
        v_rand = vr;
        h_rand = hr;
        dst_addr = addr;
        dst_length = len;
        start_cyc = cyc;
        start = 1'b1;
    endtask

    task automatic finish_xfer(input string name, input int words, input int qwords);
        int n = 0;
        while (!done_seen && n < 1000) begin
            tick();
            n++;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        v_rand = 0; h_rand = 0; data_valid = 1'b1; hready = 1'b1;
        chk({name, "_done_held"}, {31'd0, done}, 32'd1);
        chk({name, "_writes"}, wr_cnt, words);
        chk({name, "_qwords"}, hs_cnt, qwords);
        chk({name, "_sb_left"}, exp_q.size(), 0);
        if (words > 0) begin
            chk({name, "_done_lat"}, done_cyc, last_wr_cyc + 1);
        end else begin
            chk({name, "_done_lat"}, done_cyc, start_cyc + 2);
            chk({name, "_no_trans"}, trans_cnt, 0);
            chk({name, "_no_ready"}, rdy_cnt, 0);
        end
        start = 1'b0;
        tick();
        chk({name, "_done_clr"}, {31'd0, done}, 32'd0);
        exp_q.delete();
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin : test
        int n;
        vecs[0] = '{32'h0000_1000, 16'd16, 1'b0, 1'b0, 4, 2};
        vecs[1] = '{32'h0000_2004, 16'd6,  1'b0, 1'b0, 2, 2};
        vecs[2] = '{32'h0000_1000, 16'd0,  1'b0, 1'b0, 0, 0};
        vecs[3] = '{32'h0000_1000, 16'd32, 1'b1, 1'b1, 8, 4};
        vecs[4] = '{32'hFFFF_FFF8, 16'd16, 1'b0, 1'b1, 4, 2};
        vecs[5] = '{32'h0000_1004, 16'd1,  1'b0, 1'b0, 1, 1};
        vecs[6] = '{32'h0000_100C, 16'd13, 1'b1, 1'b1, 4, 3};
        vecs[7] = '{32'h0000_2000, 16'd5,  1'b1, 1'b0, 2, 1};

        repeat (3) tick();
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
        chk("rst_hsize", {29'd0, hsize}, 32'd2);
        chk("rst_hburst", {29'd0, hburst}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            begin_xfer(vecs[i].addr, vecs[i].len, vecs[i].vr, vecs[i].hr, vecs[i].words,
                       32'h5500_0000 | 32'(i << 16));
            finish_xfer($sformatf("vec%0d", i), vecs[i].words, vecs[i].qwords);
        end

        // hready low for 3 cycles while the second data phase is outstanding
        begin_xfer(32'h0000_1000, 16'd32, 1'b0, 1'b0, 8, 32'h6600_0000);
        n = 0;
        while (acc_cnt < 2 && n < 200) begin tick(); n++; end
        chk("stall_reach", acc_cnt, 2);
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_htrans", {30'd0, htrans}, 32'd2);
            chk("stall_haddr", haddr, 32'h0000_1008);
            chk("stall_hwdata", hwdata, 32'h6600_0001);
        end
        hready = 1'b1;
        finish_xfer("stall", 8, 4);

        // pause sampled on acceptance of the third address, held 5 cycles
        begin_xfer(32'h0000_1000, 16'd32, 1'b0, 1'b0, 8, 32'h7700_0000);
        n = 0;
        while (!(htrans == 2'b10 && haddr == 32'h0000_1008) && n < 200) begin tick(); n++; end
        chk("pause_reach", haddr, 32'h0000_1008);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pause_idle", {30'd0, htrans}, 32'd0);
        end
        pause = 1'b0;
        tick();
        chk("pause_resume_htrans", {30'd0, htrans}, 32'd2);
        chk("pause_resume_haddr", haddr, 32'h0000_100C);
        finish_xfer("pause", 8, 4);

        // burst marking across a 1KB boundary
        begin_xfer(32'h0000_03F8, 16'd16, 1'b0, 1'b0, 4, 32'h8800_0000);
        finish_xfer("burst", 4, 2);
        chk("burst_cnt", acc_htrans.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < acc_htrans.size()) begin
`ifdef DOWNSTREAM_INCR_BURST_EN
                chk($sformatf("burst_htrans%0d", j), {30'd0, acc_htrans[j]}, (j % 2 == 0) ? 32'd2 : 32'd3);
                chk($sformatf("burst_hburst%0d", j), {29'd0, acc_hburst[j]}, 32'd1);
`else
                chk($sformatf("burst_htrans%0d", j), {30'd0, acc_htrans[j]}, 32'd2);
                chk($sformatf("burst_hburst%0d", j), {29'd0, acc_hburst[j]}, 32'd0);
`endif
                chk($sformatf("burst_haddr%0d", j), acc_haddr[j], 32'h0000_03F8 + 32'(4 * j));
            end
        end

        // reset in the middle of a transfer, then a clean restart
        begin_xfer(32'h0000_1000, 16'd32, 1'b1, 1'b1, 8, 32'h9900_0000);
        n = 0;
        while (acc_cnt < 3 && n < 400) begin tick(); n++; end
        chk("mid_rst_reach", acc_cnt, 3);
        rst = 1'b1;
        tick();
        chk("mid_rst_htrans", {30'd0, htrans}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
        chk("mid_rst_haddr", haddr, 32'd0);
        rst = 1'b0;
        start = 1'b0;
        v_rand = 0; h_rand = 0; data_valid = 1'b1; hready = 1'b1;
        exp_q.delete();
        tick();
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        begin_xfer(32'h0000_1000, 16'd16, 1'b0, 1'b0, 4, 32'hAA00_0000);
        finish_xfer("after_rst", 4, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
